// File: rtl/evo_pkg.sv
// Shared types, species constants, FSM encoding and the evolution table.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package evo_pkg;

   typedef logic [4:0] species_t;
   typedef logic [3:0] level_t;

   // First-stage species
   localparam species_t SP_FLAME_1 = 5'd3;
   localparam species_t SP_WAVE_1  = 5'd4;
   localparam species_t SP_LEAF_1  = 5'd5;
   // Second-stage species
   localparam species_t SP_FLAME_2 = 5'd6;
   localparam species_t SP_WAVE_2  = 5'd7;
   localparam species_t SP_LEAF_2  = 5'd8;
   // Third-stage species
   localparam species_t SP_FLAME_3 = 5'd9;
   localparam species_t SP_WAVE_3  = 5'd10;
   localparam species_t SP_LEAF_3  = 5'd11;

   // Evolution happens strictly above these levels
   localparam level_t EVO_LVL_1 = 4'd5;
   localparam level_t EVO_LVL_2 = 4'd11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_FLASH  = 3'd2,
      ST_COMMIT = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

   // One stage per call; an ID with no matching rule maps to itself.
   function automatic species_t evo_target(input species_t id, input level_t lvl);
      species_t t;
      t = id;
      case (id)
         SP_FLAME_1: if (lvl > EVO_LVL_1) t = SP_FLAME_2;
         SP_WAVE_1:  if (lvl > EVO_LVL_1) t = SP_WAVE_2;
         SP_LEAF_1:  if (lvl > EVO_LVL_1) t = SP_LEAF_2;
         SP_FLAME_2: if (lvl > EVO_LVL_2) t = SP_FLAME_3;
         SP_WAVE_2:  if (lvl > EVO_LVL_2) t = SP_WAVE_3;
         SP_LEAF_2:  if (lvl > EVO_LVL_2) t = SP_LEAF_3;
         default:    t = id;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/evo_flash_timer.sv
// Frame/phase counters for the evolution flash; toggle_o/finished_o flag the tick that causes them.
// Latency: show_new_o updates the clock after the toggling tick; toggle_o/finished_o are same-cycle.
// Backpressure: none; ticks are only presented while the sequencer is flashing.
module evo_flash_timer
   import evo_pkg::*;
#(
   parameter int FLASH_FRAMES = 120,
   parameter int FLASH_PERIOD = 8
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic start_i,
   input  logic tick_i,
   output logic show_new_o,
   output logic toggle_o,
   output logic finished_o
);

   localparam int FW = $clog2(FLASH_FRAMES + 1);
   localparam int PW = $clog2(FLASH_PERIOD + 1);
   localparam logic [FW-1:0] FRAMES_MAX  = FW'(FLASH_FRAMES);
   localparam logic [FW-1:0] FRAMES_LAST = FW'(FLASH_FRAMES - 1);
   localparam logic [PW-1:0] PERIOD_LAST = PW'(FLASH_PERIOD - 1);

   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [PW-1:0] phase_cnt_q, phase_cnt_d;
   logic          show_new_q, show_new_d;

   // The tick that completes a phase / the whole animation, seen combinationally by the sequencer
   assign toggle_o   = tick_i && (phase_cnt_q == PERIOD_LAST);
   assign finished_o = tick_i && (frame_cnt_q == FRAMES_LAST);
   assign show_new_o = show_new_q;

   // Next-state: start clears everything, each tick advances both counters (saturating frames)
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      phase_cnt_d = phase_cnt_q;
      show_new_d  = show_new_q;
      if (start_i) begin
         frame_cnt_d = '0;
         phase_cnt_d = '0;
         show_new_d  = 1'b0;
      end else if (tick_i) begin
         if (frame_cnt_q != FRAMES_MAX) frame_cnt_d = frame_cnt_q + 1'b1;
         if (phase_cnt_q == PERIOD_LAST) begin
            phase_cnt_d = '0;
            show_new_d  = ~show_new_q;
         end else begin
            phase_cnt_d = phase_cnt_q + 1'b1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         frame_cnt_q <= '0;
         phase_cnt_q <= '0;
         show_new_q  <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         phase_cnt_q <= phase_cnt_d;
         show_new_q  <= show_new_d;
      end
   end

endmodule

// File: rtl/evolution_sequencer.sv
// Decides evolution on level-up, plays the cancellable sprite flash, commits the new ID.
// Latency: CHECK one clock after level_up; done one clock after the commit handshake.
// Backpressure: commit_valid/commit_ID held until commit_ready; level_up while busy is dropped.
module evolution_sequencer
   import evo_pkg::*;
#(
   parameter int FLASH_FRAMES = 120,
   parameter int FLASH_PERIOD = 8
) (
   input  logic     Clk,
   input  logic     Reset_n,
   input  logic     level_up,
   input  level_t   curr_level,
   input  species_t curr_ID,
   input  logic     frame_tick,
   input  logic     cancel,
   input  logic     commit_ready,
   output logic     busy,
   output species_t anim_ID,
   output logic     commit_valid,
   output species_t commit_ID,
   output logic     done,
   output logic     evolved
);

   state_e   state_q, state_d;
   species_t old_id_q, old_id_d;
   level_t   lvl_q, lvl_d;
   logic     busy_q, busy_d;
   species_t anim_q, anim_d;
   logic     cv_q, cv_d;
   species_t cid_q, cid_d;
   logic     done_q, done_d;
   logic     evolved_q, evolved_d;

   species_t target_w;
   logic     start_w, tick_w;
   logic     show_new_w, toggle_w, finished_w;

   // Latched values are stable from CHECK onward, so the target needs no register
   assign target_w = evo_target(old_id_q, lvl_q);
   // Cancel takes the sequence out of FLASH, so a coincident tick must not count
   assign tick_w   = frame_tick && (state_q == ST_FLASH) && !cancel;

   evo_flash_timer #(
      .FLASH_FRAMES (FLASH_FRAMES),
      .FLASH_PERIOD (FLASH_PERIOD)
   ) u_timer (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .start_i    (start_w),
      .tick_i     (tick_w),
      .show_new_o (show_new_w),
      .toggle_o   (toggle_w),
      .finished_o (finished_w)
   );

   // Sequencer next-state and registered-output next values
   always_comb begin
      state_d   = state_q;
      old_id_d  = old_id_q;
      lvl_d     = lvl_q;
      busy_d    = busy_q;
      anim_d    = anim_q;
      cv_d      = cv_q;
      cid_d     = cid_q;
      done_d    = 1'b0;
      evolved_d = evolved_q;
      start_w   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            anim_d = curr_ID;
            busy_d = 1'b0;
            if (level_up) begin
               old_id_d = curr_ID;
               lvl_d    = curr_level;
               busy_d   = 1'b1;
               state_d  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            evolved_d = 1'b0;
            if (target_w == old_id_q) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_FINISH;
            end else begin
               start_w = 1'b1;
               anim_d  = old_id_q;
               state_d = ST_FLASH;
            end
         end
         ST_FLASH: begin
            if (cancel) begin
               anim_d  = old_id_q;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_FINISH;
            end else if (finished_w) begin
               anim_d  = target_w;
               cv_d    = 1'b1;
               cid_d   = target_w;
               state_d = ST_COMMIT;
            end else if (toggle_w) begin
               anim_d = show_new_w ? old_id_q : target_w;
            end
         end
         ST_COMMIT: begin
            if (commit_ready) begin
               cv_d      = 1'b0;
               evolved_d = 1'b1;
               busy_d    = 1'b0;
               done_d    = 1'b1;
               state_d   = ST_FINISH;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset drops everything including a pending commit
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= ST_IDLE;
         old_id_q  <= '0;
         lvl_q     <= '0;
         busy_q    <= 1'b0;
         anim_q    <= '0;
         cv_q      <= 1'b0;
         cid_q     <= '0;
         done_q    <= 1'b0;
         evolved_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         old_id_q  <= old_id_d;
         lvl_q     <= lvl_d;
         busy_q    <= busy_d;
         anim_q    <= anim_d;
         cv_q      <= cv_d;
         cid_q     <= cid_d;
         done_q    <= done_d;
         evolved_q <= evolved_d;
      end
   end

   assign busy         = busy_q;
   assign anim_ID      = anim_q;
   assign commit_valid = cv_q;
   assign commit_ID    = cid_q;
   assign done         = done_q;
   assign evolved      = evolved_q;

endmodule

// File: tb/tb_evolution_sequencer.sv
// Directed bench for evolution_sequencer with a short flash (4 frames, toggle every 2).
// Latency: n/a.
// Backpressure: commit_ready driven per scenario.
module tb_evolution_sequencer;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       level_up = 1'b0;
   logic [3:0] curr_level = 4'd0;
   logic [4:0] curr_ID = 5'd0;
   logic       frame_tick = 1'b0;
   logic       cancel = 1'b0;
   logic       commit_ready = 1'b0;
   logic       busy;
   logic [4:0] anim_ID;
   logic       commit_valid;
   logic [4:0] commit_ID;
   logic       done;
   logic       evolved;

   int errors = 0;
   int checks = 0;

   evolution_sequencer #(.FLASH_FRAMES(4), .FLASH_PERIOD(2)) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .level_up     (level_up),
      .curr_level   (curr_level),
      .curr_ID      (curr_ID),
      .frame_tick   (frame_tick),
      .cancel       (cancel),
      .commit_ready (commit_ready),
      .busy         (busy),
      .anim_ID      (anim_ID),
      .commit_valid (commit_valid),
      .commit_ID    (commit_ID),
      .done         (done),
      .evolved      (evolved)
   );

   always #5 Clk = ~Clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic pulse_level_up(input logic [4:0] id, input logic [3:0] lvl);
      curr_ID = id; curr_level = lvl; level_up = 1'b1;
      step();
      level_up = 1'b0;
   endtask

   task automatic one_tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; curr_ID = 5'd3;
      #3;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
      checks++; if (anim_ID !== 5'd0) begin errors++; $display("FAIL rst_anim: got %0d want 0", anim_ID); end
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL rst_cv: got %0b want 0", commit_valid); end
      checks++; if (commit_ID !== 5'd0) begin errors++; $display("FAIL rst_cid: got %0d want 0", commit_ID); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", done); end
      checks++; if (evolved !== 1'b0) begin errors++; $display("FAIL rst_evolved: got %0b want 0", evolved); end
      @(negedge Clk);
      Reset_n = 1'b1;
      step();
      checks++; if (anim_ID !== 5'd3) begin errors++; $display("FAIL rst_idle_anim: got %0d want 3", anim_ID); end
   endtask

   task automatic test_evolve();
      commit_ready = 1'b1;
      pulse_level_up(5'd3, 4'd6);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL evo_busy_check: got %0b want 1", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL evo_done_early: got %0b want 0", done); end
      step();
      checks++; if (anim_ID !== 5'd3) begin errors++; $display("FAIL evo_anim_start: got %0d want 3", anim_ID); end
      one_tick();
      checks++; if (anim_ID !== 5'd3) begin errors++; $display("FAIL evo_anim_t1: got %0d want 3", anim_ID); end
      step();
      one_tick();
      checks++; if (anim_ID !== 5'd6) begin errors++; $display("FAIL evo_anim_t2: got %0d want 6", anim_ID); end
      one_tick();
      checks++; if (anim_ID !== 5'd6) begin errors++; $display("FAIL evo_anim_t3: got %0d want 6", anim_ID); end
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL evo_cv_early: got %0b want 0", commit_valid); end
      one_tick();
      checks++; if (anim_ID !== 5'd6) begin errors++; $display("FAIL evo_anim_final: got %0d want 6", anim_ID); end
      checks++; if (commit_valid !== 1'b1) begin errors++; $display("FAIL evo_cv: got %0b want 1", commit_valid); end
      checks++; if (commit_ID !== 5'd6) begin errors++; $display("FAIL evo_cid: got %0d want 6", commit_ID); end
      step();
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL evo_cv_drop: got %0b want 0", commit_valid); end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL evo_done: got %0b want 1", done); end
      checks++; if (evolved !== 1'b1) begin errors++; $display("FAIL evo_evolved: got %0b want 1", evolved); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL evo_busy_fin: got %0b want 0", busy); end
      step();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL evo_done_clear: got %0b want 0", done); end
      checks++; if (evolved !== 1'b1) begin errors++; $display("FAIL evo_evolved_hold: got %0b want 1", evolved); end
   endtask

   task automatic test_no_evolve();
      pulse_level_up(5'd3, 4'd5);
      checks++; if (done !== 1'b0 || commit_valid !== 1'b0) begin errors++; $display("FAIL noevo_n1: done=%0b cv=%0b want 0 0", done, commit_valid); end
      step();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL noevo_done: got %0b want 1", done); end
      checks++; if (evolved !== 1'b0) begin errors++; $display("FAIL noevo_evolved: got %0b want 0", evolved); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noevo_busy: got %0b want 0", busy); end
      checks++; if (anim_ID !== 5'd3 || commit_valid !== 1'b0) begin errors++; $display("FAIL noevo_anim_cv: anim=%0d cv=%0b want 3 0", anim_ID, commit_valid); end
      step();
      checks++; if (done !== 1'b0 || anim_ID !== 5'd3) begin errors++; $display("FAIL noevo_after: done=%0b anim=%0d want 0 3", done, anim_ID); end
   endtask

   task automatic test_cancel();
      commit_ready = 1'b1;
      pulse_level_up(5'd6, 4'd12);
      step();
      one_tick();
      one_tick();
      checks++; if (anim_ID !== 5'd9) begin errors++; $display("FAIL cancel_anim_new: got %0d want 9", anim_ID); end
      one_tick();
      cancel = 1'b1;
      step();
      cancel = 1'b0;
      checks++; if (done !== 1'b1 || evolved !== 1'b0) begin errors++; $display("FAIL cancel_done: done=%0b evolved=%0b want 1 0", done, evolved); end
      checks++; if (anim_ID !== 5'd6) begin errors++; $display("FAIL cancel_anim: got %0d want 6", anim_ID); end
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL cancel_cv: got %0b want 0", commit_valid); end
      step();
      // Level 15 on a first-stage species evolves only one stage
      pulse_level_up(5'd3, 4'd15);
      step();
      for (int i = 0; i < 4; i++) one_tick();
      checks++; if (commit_valid !== 1'b1 || commit_ID !== 5'd6) begin errors++; $display("FAIL single_stage: cv=%0b cid=%0d want 1 6", commit_valid, commit_ID); end
      step();
      checks++; if (done !== 1'b1 || evolved !== 1'b1) begin errors++; $display("FAIL single_stage_done: done=%0b evolved=%0b want 1 1", done, evolved); end
      step();
   endtask

   task automatic test_cancel_final_tick();
      pulse_level_up(5'd4, 4'd6);
      step();
      for (int i = 0; i < 3; i++) one_tick();
      frame_tick = 1'b1; cancel = 1'b1;
      step();
      frame_tick = 1'b0; cancel = 1'b0;
      checks++; if (done !== 1'b1 || evolved !== 1'b0) begin errors++; $display("FAIL coinc_done: done=%0b evolved=%0b want 1 0", done, evolved); end
      checks++; if (commit_valid !== 1'b0 || anim_ID !== 5'd4) begin errors++; $display("FAIL coinc_cv_anim: cv=%0b anim=%0d want 0 4", commit_valid, anim_ID); end
      step();
      checks++; if (commit_valid !== 1'b0) begin errors++; $display("FAIL coinc_cv_after: got %0b want 0", commit_valid); end
   endtask

   task automatic test_back_to_back();
      int bad;
      commit_ready = 1'b0;
      pulse_level_up(5'd4, 4'd9);
      step();
      for (int i = 0; i < 4; i++) one_tick();
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (commit_valid !== 1'b1 || commit_ID !== 5'd7 || busy !== 1'b1 || done !== 1'b0 || anim_ID !== 5'd7) bad++;
         curr_ID = 5'd3; curr_level = 4'd6;
         level_up = (i % 3 == 0);
         step();
      end
      level_up = 1'b0;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: unstable cycles=%0d want 0", bad); end
      checks++; if (commit_valid !== 1'b1 || commit_ID !== 5'd7) begin errors++; $display("FAIL bp_still: cv=%0b cid=%0d want 1 7", commit_valid, commit_ID); end
      commit_ready = 1'b1;
      step();
      checks++; if (done !== 1'b1 || evolved !== 1'b1 || commit_valid !== 1'b0) begin errors++; $display("FAIL bp_done: done=%0b evolved=%0b cv=%0b want 1 1 0", done, evolved, commit_valid); end
      step();
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL bp_idle: busy=%0b done=%0b want 0 0", busy, done); end
      step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_queue: busy=%0b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      commit_ready = 1'b1;
      pulse_level_up(5'd3, 4'd6);
      step();
      one_tick();
      one_tick();
      Reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || anim_ID !== 5'd0) begin errors++; $display("FAIL rmid_flash: busy=%0b anim=%0d want 0 0", busy, anim_ID); end
      #2;
      Reset_n = 1'b1;
      step();
      commit_ready = 1'b0;
      pulse_level_up(5'd5, 4'd6);
      step();
      for (int i = 0; i < 4; i++) one_tick();
      checks++; if (commit_valid !== 1'b1 || commit_ID !== 5'd8) begin errors++; $display("FAIL rmid_pre: cv=%0b cid=%0d want 1 8", commit_valid, commit_ID); end
      Reset_n = 1'b0;
      #1;
      checks++; if (commit_valid !== 1'b0 || commit_ID !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_commit: cv=%0b cid=%0d busy=%0b want 0 0 0", commit_valid, commit_ID, busy); end
      #2;
      Reset_n = 1'b1;
      commit_ready = 1'b1;
      step();
      pulse_level_up(5'd5, 4'd7);
      step();
      for (int i = 0; i < 4; i++) one_tick();
      checks++; if (commit_valid !== 1'b1 || commit_ID !== 5'd8) begin errors++; $display("FAIL rmid_restart: cv=%0b cid=%0d want 1 8", commit_valid, commit_ID); end
      step();
      checks++; if (done !== 1'b1 || evolved !== 1'b1) begin errors++; $display("FAIL rmid_done: done=%0b evolved=%0b want 1 1", done, evolved); end
      step();
   endtask

   initial begin
      test_reset();
      test_evolve();
      test_no_evolve();
      test_cancel();
      test_cancel_final_tick();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
